// File: rtl/ibr128_host_seq_if.sv
// rtl/ibr128_host_seq_if.sv - IBR128 CSR slave-port bus between host sequencer and wrapper
interface ibr128_host_seq_if;
  logic        CS;
  logic        Write;
  logic        Read;
  logic [4:0]  Addr;
  logic [31:0] WData;
  logic [31:0] RData;

  modport master (output CS, output Write, output Read, output Addr, output WData, input RData);
  modport slave  (input CS, input Write, input Read, input Addr, input WData, output RData);
endinterface

// File: rtl/ibr128_host_seq.sv
// rtl/ibr128_host_seq.sv - runs one IBR128 block operation over the CSR port from a single Start
module ibr128_host_seq #(
  parameter int POLL_MAX = 1024
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic                 LoadKey,
  input  logic                 SA,
  input  logic                 Encrypt,
  input  logic                 FB,
  input  logic [1:0]           SOM,
  input  logic [63:0]          key0In,
  input  logic [63:0]          key1In,
  input  logic [127:0]         IVIn,
  input  logic [127:0]         plainTextIn,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Error,
  output logic [127:0]         cipherTextOut,
  ibr128_host_seq_if.master    csr
);
  localparam int CW = $clog2(POLL_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_KEY, S_WR_IV, S_WR_PT, S_WR_CTRL,
    S_POLL_RD, S_POLL_CHK, S_RD_CT, S_CLR, S_DONE
  } state_t;

  state_t         state, nxt;
  logic [1:0]     idx, nxt_idx;
  logic [CW-1:0]  cnt;
  logic           err;
  logic [63:0]    key0_q, key1_q;
  logic [127:0]   iv_q, pt_q;
  logic           sa_q, enc_q, fb_q;
  logic [1:0]     som_q;
  logic [3:0][31:0] ct_q;
  logic [127:0]   ct_out;

  logic [127:0]   key_q;
  logic [6:0]     bit_off;
  logic [31:0]    ctrl_word;
  logic           poll_left;

  assign key_q     = {key1_q, key0_q};
  assign bit_off   = {idx, 5'd0};
  // Enable bit is left clear here and OR-ed in only for the start-of-operation write
  assign ctrl_word = {26'd0, fb_q, som_q, enc_q, sa_q, 1'b0};
  assign poll_left = cnt < CW'(POLL_MAX);

  assign Busy          = (state != S_IDLE) && (state != S_DONE);
  assign Done          = (state == S_DONE);
  assign Error         = err;
  assign cipherTextOut = ct_out;

  always_comb begin
    nxt       = state;
    nxt_idx   = idx;
    csr.CS    = 1'b0;
    csr.Write = 1'b0;
    csr.Read  = 1'b0;
    csr.Addr  = '0;
    csr.WData = '0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          nxt_idx = 2'd0;
          nxt     = LoadKey ? S_WR_KEY : S_WR_PT;
        end
      end
      S_WR_KEY: begin
        csr.CS = 1'b1; csr.Write = 1'b1;
        csr.Addr  = 5'h0A + {3'b0, idx};
        csr.WData = key_q[bit_off +: 32];
        nxt_idx   = idx + 2'd1;
        if (idx == 2'd3) nxt = S_WR_IV;
      end
      S_WR_IV: begin
        csr.CS = 1'b1; csr.Write = 1'b1;
        csr.Addr  = 5'h06 + {3'b0, idx};
        csr.WData = iv_q[bit_off +: 32];
        nxt_idx   = idx + 2'd1;
        if (idx == 2'd3) nxt = S_WR_PT;
      end
      S_WR_PT: begin
        csr.CS = 1'b1; csr.Write = 1'b1;
        csr.Addr  = 5'h02 + {3'b0, idx};
        csr.WData = pt_q[bit_off +: 32];
        nxt_idx   = idx + 2'd1;
        if (idx == 2'd3) nxt = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        csr.CS = 1'b1; csr.Write = 1'b1;
        csr.WData = ctrl_word | 32'd1;
        nxt       = S_POLL_RD;
      end
      S_POLL_RD: begin
        csr.CS = 1'b1; csr.Read = 1'b1;
        csr.Addr = 5'h01;
        nxt      = S_POLL_CHK;
      end
      S_POLL_CHK: begin
        if (csr.RData[0]) begin
          nxt     = S_RD_CT;
          nxt_idx = 2'd0;
        end else if (poll_left) begin
          nxt = S_POLL_RD;
        end else begin
          nxt = S_CLR;
        end
      end
      S_RD_CT: begin
        csr.CS = 1'b1; csr.Read = 1'b1;
        csr.Addr = 5'h0E + {3'b0, idx};
        nxt_idx  = idx + 2'd1;
        if (idx == 2'd3) nxt = S_CLR;
      end
      S_CLR: begin
        csr.CS = 1'b1; csr.Write = 1'b1;
        csr.WData = ctrl_word;
        nxt       = S_DONE;
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= S_IDLE;
      idx    <= 2'd0;
      cnt    <= '0;
      err    <= 1'b0;
      key0_q <= '0;
      key1_q <= '0;
      iv_q   <= '0;
      pt_q   <= '0;
      sa_q   <= 1'b0;
      enc_q  <= 1'b0;
      fb_q   <= 1'b0;
      som_q  <= 2'd0;
      ct_q   <= '0;
      ct_out <= '0;
    end else begin
      state <= nxt;
      idx   <= nxt_idx;
      case (state)
        S_IDLE: begin
          if (Start) begin
            key0_q <= key0In;
            key1_q <= key1In;
            iv_q   <= IVIn;
            pt_q   <= plainTextIn;
            sa_q   <= SA;
            enc_q  <= Encrypt;
            fb_q   <= FB;
            som_q  <= SOM;
            cnt    <= '0;
            err    <= 1'b0;
          end
        end
        S_POLL_RD:  cnt <= cnt + CW'(1);
        S_POLL_CHK: if (!csr.RData[0] && !poll_left) err <= 1'b1;
        // read data lags its strobe by one cycle, so word idx-1 lands while word idx is requested
        S_RD_CT:    if (idx != 2'd0) ct_q[idx - 2'd1] <= csr.RData;
        S_CLR:      if (!err) ct_q[3] <= csr.RData;
        S_DONE:     if (!err) ct_out <= ct_q;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/ibr128_host_seq.md
# ibr128_host_seq

Bus-initiator sequencer that drives the IBR128 CSR slave port (CS/Write/Read/Addr/WData/RData) so a datapath client can run one 128-bit block operation without a processor. On a single Start pulse it writes key/IV/plaintext and control words and polls the status word for cipher-ready. It then reads back the ciphertext, clears Enable, and returns the result with a Done pulse. It sits between a client (DMA or stream engine) and an IBR128 wrapper instance.

## Interface
- POLL_MAX, 1024: maximum status polls before timeout; ≥1.
- Clk  in  1  single clock; all logic on rising edge.
- Rst  in  1  reset, synchronous, active-high.
- Start  in  1  one-cycle request; ignored while Busy=1.
- LoadKey  in  1  1: write key0/key1/IV before plaintext; 0: reuse previously loaded values.
- SA, Encrypt, FB  in  1 each  control fields, captured at Start.
- SOM  in  2  mode field, captured at Start.
- key0In, key1In  in  64 each  keys, captured at Start.
- IVIn, plainTextIn  in  128 each  captured at Start.
- Busy  out  1  high from cycle after accepted Start through cycle before Done.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  valid with Done; 1 = poll timeout.
- cipherTextOut  out  128  result; updated only on successful completion.
- CS, Write, Read  out  1 each  CSR bus strobes.
- Addr  out  5  CSR word address.
- WData  out  32  write data.
- RData  in  32  read data; slave returns it registered, valid the cycle after the Read strobe.

## Operation
- CSR map, word addresses. 32-bit word 0 = bits 31:0.
  - 0x00 CTRL: bit0 Enable, bit1 SA, bit2 Encrypt, bits4:3 SOM, bit5 FB.
  - 0x01 STATUS: bit0 cipherReady.
  - 0x02–0x05 plainText w0..w3; 0x06–0x09 IV w0..w3.
  - 0x0A–0x0B key0 w0..w1; 0x0C–0x0D key1 w0..w1.
  - 0x0E–0x11 cipherText w0..w3.
- Bus rule: every access is one cycle with CS=1 and exactly one of Write/Read. Idle cycles drive CS=Write=Read=0, Addr=0, WData=0.
- States:
  - IDLE: on Start, capture all inputs; go to WR_KEY if LoadKey=1, else WR_PT.
  - WR_KEY: 4 writes, 0x0A..0x0D. Then WR_IV.
  - WR_IV: 4 writes, 0x06..0x09. Then WR_PT.
  - WR_PT: 4 writes, 0x02..0x05. Then WR_CTRL.
  - WR_CTRL: write 0x00 with Enable=1 and the captured fields.
  - POLL_RD: read 0x01; increment the poll counter.
  - POLL_CHK: sample RData[0].
    - 1 → RD_CT.
    - 0 and count < POLL_MAX → POLL_RD.
    - 0 and count = POLL_MAX → CLR with Error latched.
  - RD_CT: pipelined reads of 0x0E..0x11 over 4 cycles. Word n is captured the cycle after its read.
  - CLR: write 0x00 with Enable=0 (other fields retained). Overlaps capture of the last ciphertext word.
  - DONE: Done=1 for one cycle; next state IDLE.
- cipherTextOut loads from the 4 captured words in DONE when Error=0. On timeout it holds its previous value.
- Error is cleared at each accepted Start.
- Poll counter width is $clog2(POLL_MAX+1). Reset to 0 at Start; it never wraps.

## Timing
- Reset: Rst=1 at an edge forces IDLE next cycle.
  - All bus outputs 0; Busy=Done=Error=0; cipherTextOut=0; captured registers=0.
  - Mid-operation reset abandons the sequence with no CLR write. Any remaining bus strobe deasserts the cycle after reset.
- Start sampled in cycle 0 (IDLE). First bus cycle is cycle 1.
- LoadKey=1:
  - Writes in cycles 1–13 (key 1–4, IV 5–8, PT 9–12, CTRL 13).
  - Poll read in cycle 14; RData sampled in 15.
  - If ready on the first poll: CT reads in cycles 16–19, captures 17–20.
  - CLR write in cycle 20; Done in cycle 21.
- LoadKey=0: every cycle number above shifts down by 8; Done in cycle 13.
- Each not-ready poll adds 2 cycles.
- Timeout: the final poll sample is followed by CLR next cycle, then Done with Error=1.
- Start asserted in the DONE cycle is ignored. A new Start is accepted in IDLE only.

## Test plan
- Reset, then LoadKey=1 Start with key0=0x0123456789ABCDEF and STATUS returning 1 on the first poll.
  - Bus shows writes 0x0A(0x89ABCDEF), 0x0B(0x01234567), …, 0x00 with WData bit0=1 in cycle 13.
  - Done in cycle 21, Error=0, cipherTextOut equals the 4 returned words.
- LoadKey=0 Start → no accesses to 0x06..0x0D; Done in cycle 13.
- STATUS returns 0 three times, then 1 → 4 poll reads; Done in cycle 27 (LoadKey=1).
- POLL_MAX=4 and STATUS stuck at 0 → exactly 4 polls, then CLR write 0x00 with bit0=0.
  - Done with Error=1; cipherTextOut unchanged.
- Rst asserted in cycle 7 → cycle 8 shows CS=0, Busy=0; no CLR write; a fresh Start then completes normally.
- Start re-pulsed while Busy → ignored: access sequence and Done timing identical to a single Start.
